// File: rtl/afifo_wr_arb_pkg.sv
// ---------------------------------------------------------------------------
// afifo_wr_arb_pkg
// Shared types and constants for the AFIFO write-side arbiter.
//   state_t        : arbiter FSM states (ST_IDLE, ST_BURST)
//   DEF_*          : default parameter values for afifo_wr_arb
//   STALL_CNT_W    : width of the full-stall statistic counter
// ---------------------------------------------------------------------------
package afifo_wr_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_BURST_MAX  = 8;
    localparam int STALL_CNT_W    = 16;

endpackage : afifo_wr_arb_pkg

// File: rtl/afifo_wr_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Returns the first set bit of 'req'
// searching upward from ptr+1 with wrap-around, so the requester at 'ptr'
// itself has the lowest priority.
//   req   in  N       request vector
//   ptr   in  IDX_W   index of the most recently served requester
//   idx   out IDX_W   selected requester (0 when nothing is found)
//   found out 1       at least one request bit is set
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Walk the offsets from farthest to nearest so that the nearest valid
    // requester after ptr is the last (winning) assignment. One extra bit on
    // the candidate index lets ptr+offset exceed N-1 before the wrap.
    logic [IDX_W:0] cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int off = N; off >= 1; off--) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(off);
            if (cand >= (IDX_W + 1)'(N)) begin
                cand = cand - (IDX_W + 1)'(N);
            end
            if (req[cand[IDX_W-1:0]]) begin
                idx   = cand[IDX_W-1:0];
                found = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/afifo_wr_arb.sv
// ---------------------------------------------------------------------------
// afifo_wr_arb
// Round-robin arbiter sharing one AFIFO write port among NUM_REQ
// valid/ready requesters. A grant lasts until the requester marks its last
// beat or BURST_MAX beats have been written; the AFIFO full flag gates
// ready and write enable in the same cycle.
//
// Optional build macro: AFIFO_WR_ARB_STATS_EN
//   defined   -> stall_cnt counts BURST cycles where the granted requester
//                is valid but the FIFO is full (16-bit, saturating)
//   undefined -> stall_cnt is tied to zero
//
// Ports:
//   clk_wr     in  1                    write-domain clock
//   rst_wr     in  1                    synchronous active-high reset
//   req_valid  in  NUM_REQ              per-requester word valid
//   req_data   in  NUM_REQ*DATA_WIDTH   requester words, i at [i*DW +: DW]
//   req_last   in  NUM_REQ              final beat of a requester burst
//   req_ready  out NUM_REQ              per-requester accept
//   fifo_full  in  1                    AFIFO full flag
//   wr_en      out 1                    AFIFO write enable
//   wdata      out DATA_WIDTH           AFIFO write data
//   grant_id   out $clog2(NUM_REQ)      currently granted requester
//   busy       out 1                    high while a grant is held
//   stall_cnt  out 16                   full-stall statistic
// ---------------------------------------------------------------------------
module afifo_wr_arb
    import afifo_wr_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int BURST_MAX  = DEF_BURST_MAX
) (
    input  logic                          clk_wr,
    input  logic                          rst_wr,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic [STALL_CNT_W-1:0]        stall_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BC_W  = $clog2(BURST_MAX + 1);

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [BC_W-1:0]  beat_cnt;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             gnt_valid;
    logic             xfer;
    logic             burst_end;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // A beat moves only while a grant is held, the granted requester offers
    // a word and the FIFO has room. Reset masks it so nothing is written in
    // the reset cycle even if the FSM was mid-burst.
    assign gnt_valid = req_valid[grant_id];
    assign xfer      = (state == ST_BURST) && !rst_wr && gnt_valid && !fifo_full;
    assign burst_end = xfer && (req_last[grant_id] ||
                                (beat_cnt == BC_W'(BURST_MAX - 1)));

    // FSM: IDLE spends exactly one cycle choosing the next requester, BURST
    // holds that grant until last/BURST_MAX regardless of valid dropping.
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            state    <= ST_IDLE;
            rr_ptr   <= IDX_W'(NUM_REQ - 1);
            grant_id <= '0;
            beat_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                    if (burst_end) begin
                        rr_ptr <= grant_id;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Write-port muxing: only the granted requester sees ready, and the data
    // path is forced to zero outside a live grant.
    always_comb begin
        req_ready = '0;
        wr_en     = xfer;
        wdata     = '0;
        if ((state == ST_BURST) && !rst_wr) begin
            req_ready[grant_id] = !fifo_full;
            wdata = req_data[int'(grant_id) * DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef AFIFO_WR_ARB_STATS_EN
    // Count cycles where the granted requester is blocked purely by the FIFO
    // being full; saturate rather than wrap so long stalls stay visible.
    logic [STALL_CNT_W-1:0] stall_q;

    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            stall_q <= '0;
        end else if ((state == ST_BURST) && gnt_valid && fifo_full &&
                     (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule : afifo_wr_arb

// File: doc/afifo_wr_arb.md
# afifo_wr_arb

Round-robin write-port arbiter for the AFIFO write side. Shares one AFIFO write port (`wr_en`/`wdata`) among `NUM_REQ` valid/ready requesters in the `clk_wr` domain. Grants in bursts and honours back-pressure from the AFIFO full flag. Sits directly in front of the AFIFO write interface.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of each requester word and of `wdata`
- `NUM_REQ`, 4, number of requesters (2..16)
- `BURST_MAX`, 8, maximum beats per grant (1..256)

Ports:
- `clk_wr`  in  1  write-domain clock; single clock for the whole block
- `rst_wr`  in  1  reset, synchronous, active-high
- `req_valid`  in  NUM_REQ  per-requester word valid
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_last`  in  NUM_REQ  marks the final beat of a requester burst
- `req_ready`  out  NUM_REQ  per-requester accept
- `fifo_full`  in  1  AFIFO full flag, already in `clk_wr` domain
- `wr_en`  out  1  AFIFO write enable
- `wdata`  out  DATA_WIDTH  AFIFO write data
- `grant_id`  out  $clog2(NUM_REQ)  currently granted requester
- `busy`  out  1  high while a grant is held
- `stall_cnt`  out  16  full-stall statistic (see Configuration)

## Operation
- FSM states: IDLE, BURST.
- IDLE:
  - If any `req_valid` is high, select the first valid requester searching upward, with wrap, from `rr_ptr+1`.
  - Register the selection into `grant_id`, clear `beat_cnt`, and go to BURST.
  - With no valid requester, remain in IDLE.
- BURST:
  - `req_ready[grant_id] = !fifo_full`. All other `req_ready` bits are 0.
  - A transfer occurs when `req_valid[grant_id] && req_ready[grant_id]`.
  - `wr_en` equals the transfer condition, combinationally. `wdata` is the granted requester's word.
  - Each transfer increments `beat_cnt`, which is $clog2(BURST_MAX+1) bits wide.
- Burst end: a transfer with `req_last[grant_id]=1`, or a transfer that makes `beat_cnt == BURST_MAX`. On burst end, set `rr_ptr <= grant_id` and go to IDLE.
- `req_valid` dropping inside BURST does not release the grant. The grant holds until `last` or `BURST_MAX`.
- `busy` is 1 exactly in BURST.
- In IDLE: `wr_en=0`, `req_ready=0`, `wdata=0`.

## Timing
- Reset values:
  - state IDLE
  - `rr_ptr = NUM_REQ-1`, so requester 0 has first priority after reset
  - `beat_cnt=0`, `grant_id=0`, `busy=0`, `stall_cnt=0`
- Outputs during the reset cycle: `wr_en=0`, `req_ready=0`, `wdata=0`, regardless of inputs.
- Arbitration latency: `req_valid` sampled high in IDLE at edge N gives the first possible transfer in cycle N+1.
- Back-to-back bursts: exactly one IDLE cycle between bursts.
- `fifo_full` gates `req_ready` and `wr_en` in the same cycle. No write is ever issued while `fifo_full=1`. `beat_cnt` holds during stalls.
- `req_last` on the beat that also reaches `BURST_MAX` produces a single burst end.
- Reset mid-burst: the burst is abandoned without a partial-state write. The next grant follows reset priority.

## Configuration
- Macro `AFIFO_WR_ARB_STATS_EN`.
- Defined: `stall_cnt` counts cycles in BURST with `req_valid[grant_id]=1` and `fifo_full=1`. It is 16-bit, saturates at 0xFFFF, and is cleared only by reset.
- Undefined: the counter logic is absent and `stall_cnt` is tied to 0. The port list is identical in both builds.

## Structure
- Package `afifo_wr_arb_pkg`:
  - state enum (`ST_IDLE`, `ST_BURST`)
  - default parameter constants
  - `STALL_CNT_W = 16`
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are the request vector and the pointer. Outputs are the index and a found flag. It is reusable by the read-side scheduler.
- FSM, counters and output muxing live in `afifo_wr_arb`.

## Test plan
All scenarios use defaults: NUM_REQ=4, BURST_MAX=8, DATA_WIDTH=32.
- Reset: hold `rst_wr` for 2 cycles with all `req_valid=1` -> `wr_en=0`, `req_ready=0`, `busy=0` throughout. The first grant after release is `grant_id=0`.
- Single burst: req 1 presents 0xA1, 0xA2, 0xA3 with `last` on 0xA3 -> `wr_en` high for 3 cycles starting 1 cycle after `valid`, `wdata` = A1, A2, A3, then `busy=0`.
- Fairness: all 4 requesters continuously valid, never `last` -> grants 0, 1, 2, 3, 0, each 8 beats, with one idle cycle between grants.
- Back-pressure: `fifo_full=1` for 3 cycles after beat 4 of a grant -> `req_ready=0` and `wr_en=0` for those 3 cycles; burst resumes and ends at 8 beats total.
- Reset mid-burst: assert reset after beat 4 of requester 2 with requesters 0 and 3 valid -> the next grant is 0 and `beat_cnt` restarts at 0.
- Stats with `AFIFO_WR_ARB_STATS_EN`: 5 full-stall cycles -> `stall_cnt=5`. Forced long stall -> `stall_cnt` holds at 0xFFFF. Without the macro, `stall_cnt` stays 0.
